// File: rtl/pipeline_hold_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hold_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller:
//   - md_state_e : MDU sequencer state encoding (ST_IDLE, ST_BUSY)
//   - MD_TIMEOUT_DEFAULT : default watchdog limit in BUSY cycles
// ---------------------------------------------------------------------------
package pipeline_hold_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01
  } md_state_e;

  localparam int MD_TIMEOUT_DEFAULT = 64;

endpackage : pipeline_hold_ctrl_pkg

// File: rtl/pipeline_hold_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// pipeline_hold_ctrl_load_use_detect
// Combinational load-use comparator. Raises hazard when the load in EX
// writes a non-zero register that the instruction in ID actually reads.
// Priority against traps, stalls and redirects is applied by the parent.
// Ports:
//   ex_valid, ex_mem_read, ex_rd_addr   : EX stage load information
//   id_rs1_addr, id_rs2_addr            : ID source register numbers
//   id_uses_rs1, id_uses_rs2            : ID really reads that source
//   hazard                              : raw load-use hazard bit
// ---------------------------------------------------------------------------
module pipeline_hold_ctrl_load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_addr,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_match = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);

  // x0 is never written, so a load targeting it cannot create a hazard.
  assign hazard = ex_valid && ex_mem_read && (ex_rd_addr != 5'd0) &&
                  (rs1_match || rs2_match);

endmodule : pipeline_hold_ctrl_load_use_detect

// File: rtl/pipeline_hold_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hold_ctrl
// Central stall/flush controller of the 5-stage core. Generates hold/flush
// controls for PC, IF/ID, ID/EX and EX/MEM, and sequences the multi-cycle
// MDU while it occupies EX.
// Fixed priority: trap_flush > MDU busy/start > mem_stall > ex_redirect
//                 > load-use.
// Optional build macro: PIPE_CTRL_MD_WATCHDOG_EN adds a BUSY-cycle watchdog
// driving the sticky md_timeout flag (tied 0 otherwise).
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   ex_*, id_*              : EX / ID stage instruction information
//   ex_redirect, mem_stall  : branch redirect, MEM bus back-pressure
//   trap_flush              : trap / xRET flush request
//   mdu_done                : MDU result valid (level, held until mdu_ack)
//   pc_stall, ifid_stall, ifid_flush, idex_hold, idex_flush,
//   exmem_hold, exmem_bubble: pipeline register controls
//   mdu_start/ack/kill      : one-cycle pulses to the MDU
//   md_busy                 : sequencer is in BUSY (state visibility)
//   md_timeout              : sticky watchdog flag
// MDU handshake: mdu_start is a one-cycle request; mdu_done is a level that
// stays high until the cycle mdu_ack is pulsed; mdu_kill aborts without ack.
// All outputs are combinational from the state register and the inputs.
// ---------------------------------------------------------------------------
module pipeline_hold_ctrl
  import pipeline_hold_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ex_valid,
  input  logic       ex_is_mul_div,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_addr,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_redirect,
  input  logic       mem_stall,
  input  logic       trap_flush,
  input  logic       mdu_done,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_hold,
  output logic       idex_flush,
  output logic       exmem_hold,
  output logic       exmem_bubble,
  output logic       mdu_start,
  output logic       mdu_ack,
  output logic       mdu_kill,
  output logic       md_busy,
  output logic       md_timeout
);

  // Parameter sanity: no hardware is generated in either case.
  if (XLEN < 1 || MD_TIMEOUT < 2) begin : g_bad_params
  end

  md_state_e state_q, state_d;
  logic      load_use;

  pipeline_hold_ctrl_load_use_detect u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd_addr  (ex_rd_addr),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .hazard      (load_use)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_hold    = 1'b0;
    idex_flush   = 1'b0;
    exmem_hold   = 1'b0;
    exmem_bubble = 1'b0;
    mdu_start    = 1'b0;
    mdu_ack      = 1'b0;
    mdu_kill     = 1'b0;

    if (trap_flush) begin
      // Trap discards everything younger, including a running MUL/DIV.
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_bubble = 1'b1;
      mdu_kill     = (state_q == ST_BUSY);
      state_d      = ST_IDLE;
    end else if (state_q == ST_BUSY) begin
      if (mdu_done && !mem_stall) begin
        // Result retires into EX/MEM this edge; no holds, no bubble.
        mdu_ack = 1'b1;
        state_d = ST_IDLE;
      end else if (mdu_done) begin
        // MEM cannot accept yet: freeze EX/MEM, keep result pending.
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_hold  = 1'b1;
        exmem_hold = 1'b1;
      end else begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_hold    = 1'b1;
        exmem_bubble = 1'b1;
      end
    end else if (ex_valid && ex_is_mul_div) begin
      // Start cycle behaves as BUSY; mdu_done is ignored here so the MDU
      // always occupies at least one BUSY cycle.
      mdu_start    = 1'b1;
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_hold    = 1'b1;
      exmem_bubble = 1'b1;
      state_d      = ST_BUSY;
    end else if (mem_stall) begin
      // A redirect here is dropped; the branch stays in EX and re-asserts.
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  assign md_busy = (state_q == ST_BUSY);

`ifdef PIPE_CTRL_MD_WATCHDOG_EN
  localparam int CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_TIMEOUT - 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             md_timeout_q, md_timeout_d;

  always_comb begin
    wd_cnt_d     = '0;
    md_timeout_d = md_timeout_q;
    // Count only while BUSY continues; any exit clears the counter.
    if (state_q == ST_BUSY && state_d == ST_BUSY) begin
      wd_cnt_d = (wd_cnt_q == CNT_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end
    if (trap_flush) begin
      md_timeout_d = 1'b0;
    end else if (state_q == ST_BUSY && !mdu_done && wd_cnt_q == CNT_MAX) begin
      md_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q     <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      wd_cnt_q     <= wd_cnt_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  assign md_timeout = md_timeout_q;
`else
  assign md_timeout = 1'b0;
`endif

endmodule : pipeline_hold_ctrl

// File: tb/tb_pipeline_hold_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hold_ctrl
// Directed testbench for pipeline_hold_ctrl. A driver applies one input
// vector per cycle at the falling edge and queues the expected output
// vector; a monitor samples the outputs shortly after and compares.
// Output vector order (MSB..LSB): pc_stall ifid_stall ifid_flush idex_hold
// idex_flush exmem_hold exmem_bubble mdu_start mdu_ack mdu_kill md_busy
// md_timeout.
// ---------------------------------------------------------------------------
module tb_pipeline_hold_ctrl;

  localparam logic [11:0] O_PC  = 12'h800;
  localparam logic [11:0] O_IFS = 12'h400;
  localparam logic [11:0] O_IFF = 12'h200;
  localparam logic [11:0] O_IDH = 12'h100;
  localparam logic [11:0] O_IDF = 12'h080;
  localparam logic [11:0] O_EXH = 12'h040;
  localparam logic [11:0] O_BUB = 12'h020;
  localparam logic [11:0] O_STA = 12'h010;
  localparam logic [11:0] O_ACK = 12'h008;
  localparam logic [11:0] O_KIL = 12'h004;
  localparam logic [11:0] O_BSY = 12'h002;
  localparam logic [11:0] O_TO  = 12'h001;
  localparam logic [11:0] NONE  = 12'h000;
  localparam logic [11:0] STL_B = O_PC | O_IFS | O_IDH | O_BUB;
  localparam logic [11:0] STL_M = O_PC | O_IFS | O_IDH | O_EXH;
  localparam logic [11:0] LU    = O_PC | O_IFS | O_IDF;
  localparam logic [11:0] RDIR  = O_IFF | O_IDF;
  localparam logic [11:0] TRAP  = O_IFF | O_IDF | O_BUB;

  localparam logic [9:0] I_RN = 10'h200;
  localparam logic [9:0] I_V  = 10'h100;
  localparam logic [9:0] I_M  = 10'h080;
  localparam logic [9:0] I_R  = 10'h040;
  localparam logic [9:0] I_U1 = 10'h020;
  localparam logic [9:0] I_U2 = 10'h010;
  localparam logic [9:0] I_X  = 10'h008;
  localparam logic [9:0] I_S  = 10'h004;
  localparam logic [9:0] I_T  = 10'h002;
  localparam logic [9:0] I_D  = 10'h001;
  localparam logic [9:0] MUL  = I_RN | I_V | I_M;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ex_valid, ex_is_mul_div, ex_mem_read;
  logic [4:0] ex_rd_addr, id_rs1_addr, id_rs2_addr;
  logic       id_uses_rs1, id_uses_rs2;
  logic       ex_redirect, mem_stall, trap_flush, mdu_done;
  logic       pc_stall, ifid_stall, ifid_flush, idex_hold, idex_flush;
  logic       exmem_hold, exmem_bubble, mdu_start, mdu_ack, mdu_kill;
  logic       md_busy, md_timeout;

  logic [11:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  pipeline_hold_ctrl #(
    .XLEN       (32),
    .MD_TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ex_valid      (ex_valid),
    .ex_is_mul_div (ex_is_mul_div),
    .ex_mem_read   (ex_mem_read),
    .ex_rd_addr    (ex_rd_addr),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_redirect   (ex_redirect),
    .mem_stall     (mem_stall),
    .trap_flush    (trap_flush),
    .mdu_done      (mdu_done),
    .pc_stall      (pc_stall),
    .ifid_stall    (ifid_stall),
    .ifid_flush    (ifid_flush),
    .idex_hold     (idex_hold),
    .idex_flush    (idex_flush),
    .exmem_hold    (exmem_hold),
    .exmem_bubble  (exmem_bubble),
    .mdu_start     (mdu_start),
    .mdu_ack       (mdu_ack),
    .mdu_kill      (mdu_kill),
    .md_busy       (md_busy),
    .md_timeout    (md_timeout)
  );

  // Clock / reset
  always #5 clk = ~clk;

  logic [11:0] out_vec;
  assign out_vec = {pc_stall, ifid_stall, ifid_flush, idex_hold, idex_flush,
                    exmem_hold, exmem_bubble, mdu_start, mdu_ack, mdu_kill,
                    md_busy, md_timeout};

  // Driver: one vector per cycle, expected response queued alongside.
  task automatic step(input string name, input logic [9:0] ctl,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [11:0] exp);
    @(negedge clk);
    reset_n       = ctl[9];
    ex_valid      = ctl[8];
    ex_is_mul_div = ctl[7];
    ex_mem_read   = ctl[6];
    id_uses_rs1   = ctl[5];
    id_uses_rs2   = ctl[4];
    ex_redirect   = ctl[3];
    mem_stall     = ctl[2];
    trap_flush    = ctl[1];
    mdu_done      = ctl[0];
    ex_rd_addr    = rd;
    id_rs1_addr   = rs1;
    id_rs2_addr   = rs2;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic cyc(input string name, input logic [9:0] ctl,
                     input logic [11:0] exp);
    step(name, ctl, 5'd0, 5'd0, 5'd0, exp);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [11:0] exp;
    string       nm;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        checks++;
        if (out_vec !== exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b (t=%0t)", nm, out_vec, exp, $time);
        end
      end
    end
  end

  // Protocol properties watched every cycle.
  always @(posedge clk) begin
    if (reset_n === 1'b1) begin
      if (md_busy && ex_redirect) begin
        errors++;
        $display("FAIL redirect_in_busy: ex_redirect=1 while md_busy=1");
      end
      if (idex_hold && idex_flush) begin
        errors++;
        $display("FAIL idex_exclusive: idex_hold=1 and idex_flush=1");
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    {ex_valid, ex_is_mul_div, ex_mem_read, id_uses_rs1, id_uses_rs2} = '0;
    {ex_redirect, mem_stall, trap_flush, mdu_done} = '0;
    ex_rd_addr = '0; id_rs1_addr = '0; id_rs2_addr = '0;

    // Reset state
    cyc("reset0", 10'h000, NONE);
    cyc("reset1", 10'h000, NONE);
    cyc("idle",   I_RN,    NONE);

    // MUL with a 4-cycle MDU
    cyc("mul_start", MUL, STL_B | O_STA);
    for (int i = 0; i < 4; i++) cyc("mul_busy", MUL, STL_B | O_BSY);
    cyc("mul_ack",  MUL | I_D, O_ACK | O_BSY);
    // Back-to-back MUL; done still high in its start cycle is ignored
    cyc("b2b_start", MUL | I_D, STL_B | O_STA);
    for (int i = 0; i < 3; i++) cyc("done_memstall", MUL | I_D | I_S, STL_M | O_BSY);
    cyc("ack_after_stall", MUL | I_D, O_ACK | O_BSY);
    cyc("idle_after_mul", I_RN, NONE);

    // Load-use
    step("lu_rs2",       I_RN | I_V | I_R | I_U2, 5'd5, 5'd1, 5'd5, LU);
    step("lu_rd_x0",     I_RN | I_V | I_R | I_U2, 5'd0, 5'd0, 5'd0, NONE);
    step("lu_rs1",       I_RN | I_V | I_R | I_U1, 5'd7, 5'd7, 5'd2, LU);
    step("lu_rs1_unused",I_RN | I_V | I_R | I_U2, 5'd7, 5'd7, 5'd2, NONE);
    step("lu_not_load",  I_RN | I_V | I_U1,       5'd7, 5'd7, 5'd2, NONE);
    step("lu_memstall",  I_RN | I_V | I_R | I_U1 | I_S, 5'd7, 5'd7, 5'd2, STL_M);

    // Redirect under mem_stall, then released
    cyc("redir_memstall", I_RN | I_X | I_S, STL_M);
    cyc("redir_release",  I_RN | I_X,       RDIR);
    step("redir_over_lu", I_RN | I_V | I_R | I_U2 | I_X, 5'd5, 5'd0, 5'd5, RDIR);

    // Trap mid-divide
    cyc("div_start", MUL, STL_B | O_STA);
    cyc("div_busy",  MUL, STL_B | O_BSY);
    cyc("div_trap",  MUL | I_T, TRAP | O_KIL | O_BSY);
    cyc("post_trap", I_RN, NONE);
    cyc("trap_blocks_start", MUL | I_T, TRAP);
    cyc("trap_over_memstall", I_RN | I_S | I_T, TRAP);

    // Reset while BUSY returns to IDLE without ack or kill
    cyc("rst_start", MUL, STL_B | O_STA);
    cyc("rst_busy",  MUL, STL_B | O_BSY);
    cyc("rst_in_busy", 10'h000, NONE);
    cyc("rst_release", I_RN, NONE);

`ifdef PIPE_CTRL_MD_WATCHDOG_EN
    // Watchdog with MD_TIMEOUT=8: flag visible after the 8th BUSY cycle
    cyc("wd_start", MUL, STL_B | O_STA);
    for (int i = 0; i < 8; i++) cyc("wd_busy", MUL, STL_B | O_BSY);
    for (int i = 0; i < 2; i++) cyc("wd_fired", MUL, STL_B | O_BSY | O_TO);
    cyc("wd_ack",    MUL | I_D, O_ACK | O_BSY | O_TO);
    cyc("wd_sticky", I_RN, O_TO);
    cyc("wd_trap",   I_RN | I_T, TRAP | O_TO);
    cyc("wd_cleared", I_RN, NONE);
`else
    // Without the watchdog a long BUSY never raises md_timeout
    cyc("nowd_start", MUL, STL_B | O_STA);
    for (int i = 0; i < 10; i++) cyc("nowd_busy", MUL, STL_B | O_BSY);
    cyc("nowd_ack", MUL | I_D, O_ACK | O_BSY);
    cyc("nowd_idle", I_RN, NONE);
`endif

    cyc("final_idle", I_RN, NONE);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_hold_ctrl
